// File: rtl/two_inv_power_if.sv
// rtl/two_inv_power_if.sv - request/response bundle for the modular-halving power block
interface two_inv_power_if #(
   parameter int MOD_WIDTH = 256
);
   logic                 i_valid;
   logic                 i_ready;
   logic [MOD_WIDTH-1:0] i_value;
   logic [MOD_WIDTH-1:0] i_power;
   logic [MOD_WIDTH-1:0] i_modulus;
   logic                 o_valid;
   logic                 o_ready;
   logic [MOD_WIDTH-1:0] o_out;

   // requester side: issues operands, consumes the result
   modport master (
      output i_valid, i_value, i_power, i_modulus, o_ready,
      input  i_ready, o_valid, o_out
   );

   // block side: accepts operands, presents the result
   modport slave (
      input  i_valid, i_value, i_power, i_modulus, o_ready,
      output i_ready, o_valid, o_out
   );
endinterface

// File: rtl/two_inv_power.sv
// rtl/two_inv_power.sv - computes x * 2^(-k) mod N by k modular-halving rounds
module two_inv_power #(
   parameter int MOD_WIDTH = 256
) (
   input  logic          clk,
   input  logic          rst,
   two_inv_power_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t               state;
   state_t               state_nx;

   logic [MOD_WIDTH-1:0] r;
   logic [MOD_WIDTH-1:0] power;
   logic [MOD_WIDTH-1:0] modulus;
   logic [MOD_WIDTH-1:0] count;
   logic [MOD_WIDTH-1:0] count_inc;
   logic [MOD_WIDTH:0]   sum;
   logic                 ready_q;
   logic                 valid_q;
   logic                 accept;
   logic                 take;

   // ready/valid come from flops so no input reaches an output combinationally
   assign bus.i_ready = ready_q;
   assign bus.o_valid = valid_q;
   assign bus.o_out   = r;

   assign accept    = (state == IDLE) && ready_q && bus.i_valid;
   assign take      = (state == DONE) && bus.o_ready;
   assign count_inc = count + MOD_WIDTH'(1);

   // an odd r gets N added first; the extra top bit keeps the carry of r + N
   assign sum = {1'b0, r} + ({1'b0, modulus} & {(MOD_WIDTH + 1){r[0]}});

   // next-state decode
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = (bus.i_power == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (count_inc == power) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            if (take) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // state register plus handshake flags registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_nx;
         ready_q <= (state_nx == IDLE);
         valid_q <= (state_nx == DONE);
      end
   end

   // operand capture on acceptance, then one halving round per RUN cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r       <= '0;
         power   <= '0;
         modulus <= '0;
         count   <= '0;
      end else if (accept) begin
         r       <= bus.i_value;
         power   <= bus.i_power;
         modulus <= bus.i_modulus;
         count   <= '0;
      end else if (state == RUN) begin
         r       <= MOD_WIDTH'(sum >> 1);
         count   <= count_inc;
      end
   end

endmodule

// File: doc/two_inv_power.md
TWO_INV_POWER -- requirements
Module: two_inv_power

Interface
REQ-001 Parameter MOD_WIDTH, default 256: width of modulus, operand, power and result.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 i_valid  input  1  input request valid.
REQ-005 i_ready  output  1  block can accept a request.
REQ-006 i_value  input  MOD_WIDTH  operand x, required x < N.
REQ-007 i_power  input  MOD_WIDTH  number of halvings k, unsigned.
REQ-008 i_modulus  input  MOD_WIDTH  modulus N, required odd.
REQ-009 o_valid  output  1  result valid.
REQ-010 o_ready  input  1  consumer accepts result.
REQ-011 o_out  output  MOD_WIDTH  result x * 2^(-k) mod N.

Function
REQ-012 Block SHALL compute x * 2^(-k) mod N by k modular-halving rounds: the inverse of the doubling-mod-N power block, used to leave the 2^k-scaled domain.
REQ-013 Round rule SHALL be: r odd -> r = (r + N) >> 1, with the sum formed at MOD_WIDTH+1 bits with no carry loss; r even -> r = r >> 1.
REQ-014 For odd N and x < N, every intermediate r SHALL stay < N; no final subtraction.
REQ-015 FSM SHALL have three states: IDLE, RUN, DONE.
REQ-016 IDLE: i_ready=1, o_valid=0; on i_valid&&i_ready latch value, power, modulus; r=x; counter=0.
REQ-017 After acceptance, next state SHALL be DONE if k==0, else RUN.
REQ-018 RUN: i_ready=0, o_valid=0; exactly one round per cycle; counter increments.
REQ-019 RUN SHALL go to DONE in the same cycle that performs round k (counter==k-1).
REQ-020 DONE: o_valid=1, o_out=r, i_ready=0; on o_ready go to IDLE.
REQ-021 Latency: request accepted at edge t -> o_valid high from edge t+k+1; k==0 -> t+1.
REQ-022 While o_valid && !o_ready, o_out SHALL hold stable.
REQ-023 No overlap: a new request SHALL be accepted only in IDLE; i_ready SHALL be low in the cycle o_valid&&o_ready occurs.
REQ-024 Input fields SHALL be ignored outside acceptance; changes during RUN/DONE SHALL not affect the result.
REQ-025 Counter SHALL be MOD_WIDTH bits, compared for equality, never wrapping before the terminal count.
REQ-026 Even N or x >= N: result unspecified, but the k+1-cycle timing and handshake SHALL be unchanged.
REQ-027 All outputs SHALL be registered state or decoded from the FSM state only; no input-to-output combinational path.

Reset
REQ-028 While rst=1: state=IDLE, o_valid=0, o_out=0, i_ready=0, r=0, counter=0.
REQ-029 First cycle after rst deasserts: i_ready=1.
REQ-030 rst asserted in RUN or DONE SHALL abort the operation; no o_valid is produced for it.

Verification (MOD_WIDTH=8)
REQ-031 N=13, x=1, k=3 -> r sequence 7,10,5; o_out=5; o_valid exactly 4 cycles after accept.
REQ-032 N=13, x=9, k=0 -> o_out=9, o_valid 1 cycle after accept.
REQ-033 Carry bound: N=255, x=253, k=1 -> 9-bit sum 508; o_out=254.
REQ-034 Round trip: N=13, x=6 (=2^5 mod 13), k=5 -> r sequence 3,8,4,2,1; o_out=1.
REQ-035 Back-pressure: hold o_ready=0 for 5 cycles in DONE -> o_out and o_valid stable, i_ready=0; accept on o_ready=1, then i_ready=1 in the next cycle.
REQ-036 Reset mid-RUN: N=13, x=1, k=200, rst pulsed at round 50 -> o_valid never rises; i_ready=1 after rst; a following k=1 request gives o_out=7.
